// File: rtl/nbit_pipe_register.sv
// Parameterised N-bit, DEPTH-stage pipeline register with valid tracking,
// synchronous clear/set, stall enable and an occupancy count.
module nbit_pipe_register #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] SET_VALUE = '1,
  localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             R_N,
  input  logic             EN,
  input  logic             CLR,
  input  logic             S,
  input  logic             D_VALID,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [OCC_W-1:0] OCC
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OCC_W-1:0] w_occ;

  // Priority per edge: clear, then set, then advance, otherwise hold.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      // NOTE: every data stage is reset, not just the valid bits, because Q
      // must read zero while reset is asserted.
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_vld <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_vld <= '0;
    end else if (S) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= SET_VALUE;
    end else if (EN) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // old value, so the loop order does not matter.
      r_stage[0] <= D;
      r_vld[0]   <= D_VALID;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
        r_vld[i]   <= r_vld[i-1];
      end
    end
  end

  always_comb begin
    // NOTE: the default before the loop keeps this purely combinational.
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) w_occ = w_occ + OCC_W'(r_vld[i]);
  end

  assign Q       = r_stage[DEPTH-1];
  assign Q_VALID = r_vld[DEPTH-1];
  assign OCC     = w_occ;

endmodule

// File: tb/tb_nbit_pipe_register.sv
// Bench for nbit_pipe_register: three instances (8x3, 1x1, 32x16) share one
// stimulus stream and are compared against a queue-based history model.
module tb_nbit_pipe_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r_n, en, clr, s, d_valid;
  logic [31:0] d;

  logic [7:0]  q_a;  logic qv_a;  logic [1:0] occ_a;
  logic        q_b;  logic qv_b;  logic [0:0] occ_b;
  logic [31:0] q_c;  logic qv_c;  logic [4:0] occ_c;

  nbit_pipe_register #(.WIDTH(8), .DEPTH(3)) dut_a (
    .CLK(clk), .R_N(r_n), .EN(en), .CLR(clr), .S(s), .D_VALID(d_valid),
    .D(d[7:0]), .Q(q_a), .Q_VALID(qv_a), .OCC(occ_a));

  nbit_pipe_register #(.WIDTH(1), .DEPTH(1)) dut_b (
    .CLK(clk), .R_N(r_n), .EN(en), .CLR(clr), .S(s), .D_VALID(d_valid),
    .D(d[0]), .Q(q_b), .Q_VALID(qv_b), .OCC(occ_b));

  nbit_pipe_register #(.WIDTH(32), .DEPTH(16)) dut_c (
    .CLK(clk), .R_N(r_n), .EN(en), .CLR(clr), .S(s), .D_VALID(d_valid),
    .D(d), .Q(q_c), .Q_VALID(qv_c), .OCC(occ_c));

  // Model: per instance, a queue of the last DEPTH accepted words, newest at
  // the front; the oldest entry is what Q must show.
  typedef struct packed {logic v; logic [31:0] d;} word_t;
  word_t       mq [3][$];
  int          dep  [3] = '{3, 1, 16};
  logic [31:0] mask [3] = '{32'hFF, 32'h1, 32'hFFFF_FFFF};

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      for (int j = 0; j < dep[k]; j++) mq[k].push_back('0);
    end
  endtask

  task automatic model_edge(input logic i_en, i_clr, i_s, i_dv, input logic [31:0] i_d);
    if (!r_n) return;
    for (int k = 0; k < 3; k++) begin
      if (i_clr) begin
        for (int j = 0; j < dep[k]; j++) mq[k][j] = '0;
      end else if (i_s) begin
        for (int j = 0; j < dep[k]; j++) mq[k][j] = '{v: mq[k][j].v, d: mask[k]};
      end else if (i_en) begin
        mq[k].push_front('{v: i_dv, d: i_d & mask[k]});
        void'(mq[k].pop_back());
      end
    end
  endtask

  function automatic logic [31:0] exp_q(input int k);
    return mq[k][dep[k]-1].d;
  endfunction

  function automatic logic exp_v(input int k);
    return mq[k][dep[k]-1].v;
  endfunction

  function automatic int exp_occ(input int k);
    int n = 0;
    foreach (mq[k][j]) n += int'(mq[k][j].v);
    return n;
  endfunction

  // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic i_en, i_clr, i_s, i_dv, input logic [31:0] i_d);
    en = i_en; clr = i_clr; s = i_s; d_valid = i_dv; d = i_d;
    @(posedge clk);
    model_edge(i_en, i_clr, i_s, i_dv, i_d);
    #1;
  endtask

  task automatic async_reset();
    r_n = 1'b0;
    model_reset();
    #2;
    r_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (q_a !== 8'h00 || qv_a !== 1'b0 || occ_a !== 2'd0) begin
      bad++;
      $display("FAIL reset_initial q=%h v=%b occ=%0d expected q=00 v=0 occ=0", q_a, qv_a, occ_a);
    end
    #9 r_n = 1'b1;
    for (int n = 0; n < 3; n++) step(1, 0, 0, 1, 32'hA5);
    total++;
    if (q_a !== 8'hA5 || qv_a !== 1'b1 || occ_a !== 2'd3) begin
      bad++;
      $display("FAIL reset_fill q=%h v=%b occ=%0d expected q=a5 v=1 occ=3", q_a, qv_a, occ_a);
    end
    r_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (q_a !== 8'h00 || qv_a !== 1'b0 || occ_a !== 2'd0) begin
      bad++;
      $display("FAIL reset_async q=%h v=%b occ=%0d expected q=00 v=0 occ=0", q_a, qv_a, occ_a);
    end
    step(1, 0, 1, 1, 32'hFF);
    total++;
    if (q_a !== 8'h00 || qv_a !== 1'b0 || occ_a !== 2'd0) begin
      bad++;
      $display("FAIL reset_held q=%h v=%b occ=%0d expected q=00 v=0 occ=0", q_a, qv_a, occ_a);
    end
    r_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [7:0] eq [6];
    logic       ev [6];
    logic [1:0] eo [6];
    logic [7:0] w  [4];
    eq = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    eo = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
    w  = '{8'h11, 8'h22, 8'h33, 8'h44};
    async_reset();
    for (int n = 0; n < 6; n++) begin
      step(1, 0, 0, n < 4, (n < 4) ? 32'(w[n]) : 32'h0);
      total++;
      if (q_a !== eq[n] || qv_a !== ev[n] || occ_a !== eo[n]) begin
        bad++;
        $display("FAIL latency edge%0d q=%h v=%b occ=%0d expected q=%h v=%b occ=%0d",
                 n + 1, q_a, qv_a, occ_a, eq[n], ev[n], eo[n]);
      end
    end
  endtask

  task automatic test_stall();
    async_reset();
    step(1, 0, 0, 1, 32'h11);
    step(1, 0, 0, 1, 32'h22);
    for (int n = 0; n < 4; n++) begin
      step(0, 0, 0, 1, 32'hFF);
      total++;
      if (q_a !== 8'h00 || qv_a !== 1'b0 || occ_a !== 2'd2) begin
        bad++;
        $display("FAIL stall_hold%0d q=%h v=%b occ=%0d expected q=00 v=0 occ=2", n, q_a, qv_a, occ_a);
      end
    end
    step(1, 0, 0, 0, 32'h0);
    total++;
    if (q_a !== 8'h11 || qv_a !== 1'b1 || occ_a !== 2'd2) begin
      bad++;
      $display("FAIL stall_resume1 q=%h v=%b occ=%0d expected q=11 v=1 occ=2", q_a, qv_a, occ_a);
    end
    step(1, 0, 0, 0, 32'h0);
    total++;
    if (q_a !== 8'h22 || qv_a !== 1'b1 || occ_a !== 2'd1) begin
      bad++;
      $display("FAIL stall_resume2 q=%h v=%b occ=%0d expected q=22 v=1 occ=1", q_a, qv_a, occ_a);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] eq [3];
    logic       ev [3];
    logic [1:0] eo [3];
    eq = '{8'h01, 8'h02, 8'h03};
    ev = '{1'b1, 1'b0, 1'b1};
    eo = '{2'd2, 2'd1, 2'd1};
    async_reset();
    step(1, 0, 0, 1, 32'h01);
    step(1, 0, 0, 0, 32'h02);
    step(1, 0, 0, 1, 32'h03);
    for (int n = 0; n < 3; n++) begin
      if (n > 0) step(1, 0, 0, 0, 32'h0);
      total++;
      if (q_a !== eq[n] || qv_a !== ev[n] || occ_a !== eo[n]) begin
        bad++;
        $display("FAIL bubbles%0d q=%h v=%b occ=%0d expected q=%h v=%b occ=%0d",
                 n, q_a, qv_a, occ_a, eq[n], ev[n], eo[n]);
      end
    end
  endtask

  task automatic test_set_clear();
    async_reset();
    for (int n = 0; n < 3; n++) step(1, 0, 0, 1, 32'h5A);
    step(1, 0, 1, 1, 32'h77);
    total++;
    if (q_a !== 8'hFF || qv_a !== 1'b1 || occ_a !== 2'd3) begin
      bad++;
      $display("FAIL set q=%h v=%b occ=%0d expected q=ff v=1 occ=3", q_a, qv_a, occ_a);
    end
    step(1, 0, 0, 0, 32'h0);
    total++;
    if (q_a !== 8'hFF || qv_a !== 1'b1 || occ_a !== 2'd2) begin
      bad++;
      $display("FAIL set_shift q=%h v=%b occ=%0d expected q=ff v=1 occ=2", q_a, qv_a, occ_a);
    end
    step(1, 1, 1, 1, 32'hAA);
    total++;
    if (q_a !== 8'h00 || qv_a !== 1'b0 || occ_a !== 2'd0) begin
      bad++;
      $display("FAIL clr_over_set q=%h v=%b occ=%0d expected q=00 v=0 occ=0", q_a, qv_a, occ_a);
    end
  endtask

  task automatic test_sweep();
    async_reset();
    for (int n = 1; n <= 16; n++) begin
      step(1, 0, 0, 1, 32'h100 + 32'(n));
      total++;
      if (q_b !== n[0] || qv_b !== 1'b1 || occ_b !== 1'b1) begin
        bad++;
        $display("FAIL sweep_d1 edge%0d q=%b v=%b occ=%0d expected q=%b v=1 occ=1",
                 n, q_b, qv_b, occ_b, n[0]);
      end
      if (n >= 15) begin
        total++;
        if (qv_c !== (n == 16) || occ_c !== 5'(n) || (n == 16 && q_c !== 32'h101)) begin
          bad++;
          $display("FAIL sweep_d16 edge%0d q=%h v=%b occ=%0d expected v=%b occ=%0d q=00000101",
                   n, q_c, qv_c, occ_c, n == 16, n);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] aq;
    logic        av;
    int          ao;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(79) == 0) async_reset();
      step($urandom_range(3) != 0, $urandom_range(19) == 0, $urandom_range(19) == 0,
           1'($urandom_range(1)), $urandom);
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin aq = 32'(q_a); av = qv_a; ao = int'(occ_a); end
          1:       begin aq = 32'(q_b); av = qv_b; ao = int'(occ_b); end
          default: begin aq = q_c;      av = qv_c; ao = int'(occ_c); end
        endcase
        total++;
        if (aq !== exp_q(k) || av !== exp_v(k) || ao != exp_occ(k)) begin
          bad++;
          $display("FAIL random cyc%0d dut%0d q=%h v=%b occ=%0d expected q=%h v=%b occ=%0d",
                   n, k, aq, av, ao, exp_q(k), exp_v(k), exp_occ(k));
        end
      end
    end
  endtask

  initial begin
    r_n = 1'b0; en = 1'b0; clr = 1'b0; s = 1'b0; d_valid = 1'b0; d = '0;
    model_reset();
    test_reset();
    test_latency();
    test_stall();
    test_bubbles();
    test_set_clear();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nbit_pipe_register.md
NBIT_PIPE_REGISTER -- requirements
Module: nbit_pipe_register

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per stage, legal range 1..64.
REQ-002 Parameter: DEPTH, default 2, number of pipeline stages, legal range 1..16.
REQ-003 Parameter: SET_VALUE, default all-ones (WIDTH bits), value loaded by synchronous set.
REQ-004 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: R_N  input  1  reset, asynchronous, active-low.
REQ-006 Port: EN  input  1  advance enable; 0 = stall/hold all stages.
REQ-007 Port: CLR  input  1  synchronous clear of all data and valid bits.
REQ-008 Port: S  input  1  synchronous set of all stage data to SET_VALUE.
REQ-009 Port: D_VALID  input  1  D carries a valid word this cycle.
REQ-010 Port: D  input  WIDTH  data into stage 0.
REQ-011 Port: Q  output  WIDTH  data of stage DEPTH-1, registered, no combinational path from any input.
REQ-012 Port: Q_VALID  output  1  valid bit of stage DEPTH-1.
REQ-013 Port: OCC  output  $clog2(DEPTH+1)  count of stages whose valid bit is 1.

Function
REQ-014 State: DEPTH data registers stage[0..DEPTH-1] and DEPTH valid bits vld[0..DEPTH-1].
REQ-015 Per-edge priority: R_N low > CLR > S > EN > hold.
REQ-016 CLR=1: all stage data = 0 and all vld = 0 at next edge, regardless of S, EN, D_VALID.
REQ-017 S=1 (CLR=0): all stage data = SET_VALUE at next edge; vld bits unchanged; no shift occurs that cycle even if EN=1; D is dropped.
REQ-018 EN=1 (CLR=0, S=0): stage[0] <= D, vld[0] <= D_VALID; stage[i] <= stage[i-1], vld[i] <= vld[i-1] for i=1..DEPTH-1.
REQ-019 EN=0 (CLR=0, S=0): all stage data and vld bits hold; D and D_VALID ignored.
REQ-020 Latency: a word presented with EN=1 at edge k appears on Q/Q_VALID after edge k+DEPTH-1 provided EN=1 on every intervening edge; each EN=0 edge adds one cycle.
REQ-021 Data moves with its valid bit; stage data with vld=0 still shifts (invalid bubbles carry data, Q is not forced to 0).
REQ-022 DEPTH=1: single register, Q = stage[0], Q_VALID = vld[0].
REQ-023 OCC is combinational from registered vld bits only, range 0..DEPTH; OCC=DEPTH when all stages valid, no overflow/wrap.
REQ-024 No backpressure: a valid word in stage DEPTH-1 is overwritten on the next EN=1 edge whether or not it was consumed.
REQ-025 Simultaneous CLR and S: CLR wins; result all zeros, OCC=0.

Reset
REQ-026 R_N=0 immediately (no clock required) forces all stage data = 0, all vld = 0, Q=0, Q_VALID=0, OCC=0.
REQ-027 R_N=0 held: all inputs ignored, outputs stay at reset values.
REQ-028 R_N deassertion asynchronous to CLK; first update occurs on the first rising edge with R_N=1 sampled high.
REQ-029 Reset mid-stream discards all in-flight words; no partial shift is visible.

Verification (WIDTH=8, DEPTH=3 unless stated)
REQ-030 Reset: drive R_N=0 between edges with pipeline full of 0xA5 -> Q=0x00, Q_VALID=0, OCC=0 before next edge.
REQ-031 Latency: EN=1, D_VALID=1, D=0x11,0x22,0x33,0x44 on consecutive edges -> Q=0x11 with Q_VALID=1 after 3rd edge, 0x44 after 6th; OCC peaks at 3.
REQ-032 Stall: load 0x11,0x22, hold EN=0 for 4 edges with D=0xFF -> Q/OCC unchanged during stall; 0x11 reaches Q one edge per EN=1 edge thereafter.
REQ-033 Bubbles: D_VALID pattern 1,0,1 with D=0x01,0x02,0x03 -> Q sequence 0x01/0x02/0x03 with Q_VALID 1/0/1; OCC=2 after 3rd edge.
REQ-034 Set/clear priority: full pipeline, S=1 one edge -> all stages 0xFF, OCC=3; then CLR=1,S=1,EN=1 -> Q=0x00, Q_VALID=0, OCC=0.
REQ-035 Parameter sweep: repeat REQ-031 with WIDTH=1/DEPTH=1 and WIDTH=32/DEPTH=16 -> latency DEPTH-1 edges after capture, OCC max = DEPTH.
